banked_ram: RTL and testbench

//  Parametrised banked single-port RAM; the generalised successor of the fixed 16-bit hierarchical RAM stack.

---
 rtl/banked_ram.sv | 107 ++++++++++
 tb/tb_banked_ram.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_ram.sv
// Banked single-port RAM: the upper address bits select a bank and the lower bits a word in it.
// It has a valid/ready request port, a registered read response that can be held off, and an optional zero-fill after reset.
module banked_ram #(
  parameter int WIDTH        = 16,
  parameter int ADDR_W       = 12,
  parameter int BANK_BITS    = 3,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              init_done
);

  // state | meaning
  // INIT  | zero-fill one offset per cycle in every bank (one idle cycle when not clearing); requests blocked
  // RUN   | normal operation, one request per cycle

  localparam int OFF_W = ADDR_W - BANK_BITS;
  localparam int BANKS = 1 << BANK_BITS;
  localparam int DEPTH = 1 << OFF_W;
  localparam bit CLEAR = (CLEAR_ON_RST != 0);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [OFF_W-1:0]     cnt;
  logic [BANK_BITS-1:0] bank;
  logic [OFF_W-1:0]     off;
  logic                 running;
  logic                 fill_we;
  logic                 acc;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [WIDTH-1:0]     bank_rd [BANKS];

  assign bank   = req_addr[ADDR_W-1 -: BANK_BITS];
  assign off    = req_addr[OFF_W-1:0];
  assign acc    = req_valid && req_ready;
  assign wr_acc = acc && req_we;
  assign rd_acc = acc && !req_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) cnt <= cnt + OFF_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (!CLEAR || cnt == '1) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  // Gating with rst keeps a request from being accepted in the cycle that the reset is sampled.
  always_comb begin
    running   = (state == S_RUN) && !rst;
    init_done = (state == S_RUN);
    req_ready = running && (!rsp_valid || rsp_ready);
    fill_we   = (state == S_INIT) && CLEAR && !rst;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (fill_we) begin
        mem[cnt] <= '0;
      end else if (wr_acc && bank == BANK_BITS'(b)) begin
        mem[off] <= req_wdata;
      end
    end

    assign bank_rd[b] = mem[off];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (rd_acc) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= bank_rd[bank];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_banked_ram.sv
// Scoreboard bench for banked_ram. It drives the default instance and two small instances (with and without zero-fill).
// A shared request bus is routed to one instance at a time.
module tb_banked_ram;

  logic        clk = 1'b0;
  logic [2:0]  rst_v;
  logic [1:0]  sel;
  logic        req_valid, req_we, rsp_ready;
  logic [11:0] req_addr;
  logic [15:0] req_wdata;

  logic        rdy0, rv0, idn0;
  logic [15:0] rd0;
  logic        rdy1, rv1, idn1;
  logic [7:0]  rd1;
  logic        rdy2, rv2, idn2;
  logic [7:0]  rd2;

  logic        rdy, rv, idn;
  logic [15:0] rd;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] sb [$];
  logic [15:0] exp_d;

  always #5 clk = ~clk;

  banked_ram u_dut0 (
    .clk(clk), .rst(rst_v[0]),
    .req_valid(req_valid && sel == 2'd0), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .init_done(idn0)
  );

  banked_ram #(.WIDTH(8), .ADDR_W(6), .BANK_BITS(2), .CLEAR_ON_RST(1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]),
    .req_valid(req_valid && sel == 2'd1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr[5:0]), .req_wdata(req_wdata[7:0]),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .init_done(idn1)
  );

  banked_ram #(.WIDTH(8), .ADDR_W(6), .BANK_BITS(2), .CLEAR_ON_RST(0)) u_dut2 (
    .clk(clk), .rst(rst_v[2]),
    .req_valid(req_valid && sel == 2'd2), .req_ready(rdy2), .req_we(req_we),
    .req_addr(req_addr[5:0]), .req_wdata(req_wdata[7:0]),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .init_done(idn2)
  );

  assign rdy = (sel == 2'd0) ? rdy0 : (sel == 2'd1) ? rdy1 : rdy2;
  assign rv  = (sel == 2'd0) ? rv0  : (sel == 2'd1) ? rv1  : rv2;
  assign idn = (sel == 2'd0) ? idn0 : (sel == 2'd1) ? idn1 : idn2;
  assign rd  = (sel == 2'd0) ? rd0  : (sel == 2'd1) ? {8'h00, rd1} : {8'h00, rd2};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Responses are taken at the edge after a negedge that sees valid && ready
  always @(negedge clk) begin
    if (rv && rsp_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got 0x%0h with empty scoreboard", rd);
      end else begin
        exp_d = sb.pop_front();
        check("rsp_data", {16'h0, rd}, {16'h0, exp_d});
      end
    end
  end

  task automatic do_req(input logic we, input logic [11:0] a, input logic [15:0] d,
                        input logic [15:0] expv, input bit push);
    int w;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    w = 0;
    @(negedge clk);
    while (!rdy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_timeout: addr 0x%0h never accepted", a);
    end
    @(posedge clk);
    if (!we && push) sb.push_back(expv);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst_v[sel] = 1'b1;
    step();
    check("rst_req_ready", rdy, 0);
    check("rst_rsp_valid", rv, 0);
    check("rst_rsp_rdata", rd, 0);
    check("rst_init_done", idn, 0);
    rst_v[sel] = 1'b0;
  endtask

  task automatic wait_init(input int expc);
    int c;
    int rdy_hi;
    c = 0;
    rdy_hi = 0;
    while (!idn && c < 4000) begin
      if (rdy) rdy_hi++;
      step();
      c++;
    end
    check("init_cycles", c, expc);
    check("ready_during_init", rdy_hi, 0);
    check("ready_after_init", rdy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int ones;
    logic last;
    sel       = 2'd0;
    rst_v     = 3'b111;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    #1;
    repeat (2) step();
    rst_v[2:1] = 2'b00;

    // 1: zero-fill timing and an all-zero sweep
    pulse_rst();
    wait_init(512);
    for (int a = 0; a < 4096; a++) do_req(1'b0, 12'(a), 16'h0, 16'h0000, 1'b1);

    // 2: bank-boundary writes
    do_req(1'b1, 12'h000, 16'hBEEF, 16'h0, 1'b0);
    do_req(1'b1, 12'h1FF, 16'hCAFE, 16'h0, 1'b0);
    do_req(1'b1, 12'h200, 16'h1234, 16'h0, 1'b0);
    do_req(1'b1, 12'hFFF, 16'hFFFF, 16'h0, 1'b0);
    do_req(1'b0, 12'h000, 16'h0, 16'hBEEF, 1'b1);
    do_req(1'b0, 12'h1FF, 16'h0, 16'hCAFE, 1'b1);
    do_req(1'b0, 12'h200, 16'h0, 16'h1234, 1'b1);
    do_req(1'b0, 12'hFFF, 16'h0, 16'hFFFF, 1'b1);
    do_req(1'b0, 12'h1FE, 16'h0, 16'h0000, 1'b1);
    do_req(1'b0, 12'h201, 16'h0, 16'h0000, 1'b1);

    // 3: back-to-back reads, one response per cycle
    ones = 0;
    last = 1'b1;
    fork
      for (int i = 0; i < 8; i++)
        do_req(1'b0, 12'(i), 16'h0, (i == 0) ? 16'hBEEF : 16'h0000, 1'b1);
      begin
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          if (i < 8) ones += int'(rv);
          else last = rv;
        end
      end
    join
    check("b2b_valid_run", ones, 8);
    check("b2b_valid_end", last, 0);

    // 4: stall with a queued read
    do_req(1'b1, 12'h010, 16'h0A0A, 16'h0, 1'b0);
    do_req(1'b1, 12'h011, 16'h0B0B, 16'h0, 1'b0);
    do_req(1'b0, 12'h010, 16'h0, 16'h0A0A, 1'b1);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 12'h011;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", rv, 1);
      check("stall_data", rd, 16'h0A0A);
      check("stall_ready", rdy, 0);
    end
    step();
    rsp_ready = 1'b1;
    #1;
    check("release_ready", rdy, 1);
    @(posedge clk);
    sb.push_back(16'h0B0B);
    #1;
    req_valid = 1'b0;
    step();

    // 5: write-then-read, and a write withdrawn during a stall
    do_req(1'b1, 12'h055, 16'h5A5A, 16'h0, 1'b0);
    do_req(1'b0, 12'h055, 16'h0, 16'h5A5A, 1'b1);
    do_req(1'b0, 12'h000, 16'h0, 16'hBEEF, 1'b1);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 12'h056;
    req_wdata = 16'h7777;
    repeat (3) begin
      @(negedge clk);
      check("stall_wr_ready", rdy, 0);
    end
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    step();
    do_req(1'b0, 12'h056, 16'h0, 16'h0000, 1'b1);
    do_req(1'b1, 12'h056, 16'h7777, 16'h0, 1'b0);
    do_req(1'b0, 12'h056, 16'h0, 16'h7777, 1'b1);

    // 6: reset with a pending response
    do_req(1'b0, 12'h055, 16'h0, 16'h0, 1'b0);
    rsp_ready = 1'b0;
    check("pending_valid", rv, 1);
    pulse_rst();
    rsp_ready = 1'b1;
    wait_init(512);
    do_req(1'b0, 12'h055, 16'h0, 16'h0000, 1'b1);
    do_req(1'b0, 12'h000, 16'h0, 16'h0000, 1'b1);
    repeat (3) step();

    // Small instance with zero-fill
    sel = 2'd1;
    pulse_rst();
    wait_init(16);
    do_req(1'b1, 12'h03F, 16'h00A5, 16'h0, 1'b0);
    do_req(1'b1, 12'h010, 16'h003C, 16'h0, 1'b0);
    do_req(1'b0, 12'h03F, 16'h0, 16'h00A5, 1'b1);
    do_req(1'b0, 12'h010, 16'h0, 16'h003C, 1'b1);
    do_req(1'b0, 12'h00F, 16'h0, 16'h0000, 1'b1);
    do_req(1'b0, 12'h020, 16'h0, 16'h0000, 1'b1);
    do_req(1'b0, 12'h03F, 16'h0, 16'h0, 1'b0);
    rsp_ready = 1'b0;
    pulse_rst();
    rsp_ready = 1'b1;
    wait_init(16);
    do_req(1'b0, 12'h03F, 16'h0, 16'h0000, 1'b1);
    do_req(1'b0, 12'h010, 16'h0, 16'h0000, 1'b1);
    repeat (3) step();

    // Small instance without zero-fill: contents survive reset
    sel = 2'd2;
    pulse_rst();
    wait_init(1);
    do_req(1'b1, 12'h021, 16'h003C, 16'h0, 1'b0);
    do_req(1'b1, 12'h012, 16'h00C3, 16'h0, 1'b0);
    pulse_rst();
    wait_init(1);
    do_req(1'b0, 12'h021, 16'h0, 16'h003C, 1'b1);
    do_req(1'b0, 12'h012, 16'h0, 16'h00C3, 1'b1);
    repeat (3) step();

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
